// File: rtl/branch_pkg.sv
// Shared opcode encodings, flag bit positions and the taken/illegal decode.
// Pure definitions, no timing; backpressure does not apply.
// Imported by branch_cond_unit and its sub-modules.
package branch_pkg;

    localparam logic [2:0] OP_BEQ = 3'd0;
    localparam logic [2:0] OP_BNE = 3'd1;
    localparam logic [2:0] OP_BLT = 3'd2;
    localparam logic [2:0] OP_BGE = 3'd3;
    localparam logic [2:0] OP_BGT = 3'd4;
    localparam logic [2:0] OP_BLE = 3'd5;

    // Flag vector layout is {lt, eq, gt}.
    localparam int FLAG_LT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_GT = 0;

    localparam int TAKEN_CNT_W = 16;

    function automatic logic op_taken(input logic [2:0] op, input logic [2:0] flags);
        case (op)
            OP_BEQ:  return flags[FLAG_EQ];
            OP_BNE:  return !flags[FLAG_EQ];
            OP_BLT:  return flags[FLAG_LT];
            OP_BGE:  return !flags[FLAG_LT];
            OP_BGT:  return flags[FLAG_GT];
            OP_BLE:  return !flags[FLAG_GT];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_BLE;
    endfunction

endpackage

// File: rtl/branch_cond_unit_mag_compare.sv
// Magnitude comparator producing one-hot lt/eq/gt for unsigned or two's complement operands.
// Combinational, zero latency.
// No backpressure; the result follows the inputs.
module mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] a_adj;
    logic [WIDTH-1:0] b_adj;

    // Flipping the sign bits maps two's complement order onto unsigned order.
    always_comb begin
        a_adj = a;
        b_adj = b;
        if (is_signed) begin
            a_adj[WIDTH-1] = ~a[WIDTH-1];
            b_adj[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    assign eq = (a == b);
    assign lt = (a_adj < b_adj);
    assign gt = !lt && !eq;

endmodule

// File: rtl/branch_cond_unit.sv
// Two-stage branch-condition resolver: S1 holds flags/op/tag, S2 holds taken/illegal/flags/tag.
// Latency 2 edges from accept to out_valid; one result per cycle under continuous out_ready.
// Stages hold under out_ready=0; in_ready is combinational from out_ready. Signed compare: BRANCH_SIGNED_EN.
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [2:0]             in_op,
`ifdef BRANCH_SIGNED_EN
    input  logic                   in_signed,
`endif
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_taken,
    output logic                   out_illegal,
    output logic [2:0]             out_flags,
    output logic [TAG_W-1:0]       out_tag,
    output logic [TAKEN_CNT_W-1:0] taken_cnt
);

    logic                   s1_vld_q, s1_vld_d;
    logic [2:0]             s1_flags_q, s1_flags_d;
    logic [2:0]             s1_op_q, s1_op_d;
    logic [TAG_W-1:0]       s1_tag_q, s1_tag_d;
    logic                   s2_vld_q, s2_vld_d;
    logic                   s2_taken_q, s2_taken_d;
    logic                   s2_illegal_q, s2_illegal_d;
    logic [2:0]             s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0]       s2_tag_q, s2_tag_d;
    logic [TAKEN_CNT_W-1:0] cnt_q, cnt_d;

    logic cmp_signed;
    logic cmp_lt, cmp_eq, cmp_gt;
    logic s2_free, s1_adv, in_hs, out_hs;

`ifdef BRANCH_SIGNED_EN
    assign cmp_signed = in_signed;
`else
    assign cmp_signed = 1'b0;
`endif

    mag_compare #(.WIDTH(WIDTH)) u_cmp (
        .a         (in_a),
        .b         (in_b),
        .is_signed (cmp_signed),
        .lt        (cmp_lt),
        .eq        (cmp_eq),
        .gt        (cmp_gt)
    );

    assign out_hs   = s2_vld_q && out_ready;
    assign s2_free  = !s2_vld_q || out_ready;
    assign s1_adv   = s1_vld_q && s2_free;
    assign in_ready = !flush && (!s1_vld_q || s2_free);
    assign in_hs    = in_valid && in_ready;

    always_comb begin
        s1_vld_d     = s1_vld_q;
        s1_flags_d   = s1_flags_q;
        s1_op_d      = s1_op_q;
        s1_tag_d     = s1_tag_q;
        s2_vld_d     = s2_vld_q;
        s2_taken_d   = s2_taken_q;
        s2_illegal_d = s2_illegal_q;
        s2_flags_d   = s2_flags_q;
        s2_tag_d     = s2_tag_q;
        cnt_d        = cnt_q;

        if (in_hs) begin
            s1_vld_d   = 1'b1;
            s1_flags_d = {cmp_lt, cmp_eq, cmp_gt};
            s1_op_d    = in_op;
            s1_tag_d   = in_tag;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        if (s1_adv) begin
            s2_vld_d     = 1'b1;
            s2_taken_d   = op_taken(s1_op_q, s1_flags_q);
            s2_illegal_d = op_illegal(s1_op_q);
            s2_flags_d   = s1_flags_q;
            s2_tag_d     = s1_tag_q;
        end else if (out_hs) begin
            s2_vld_d = 1'b0;
        end

        // A result handshaken during flush still counts as delivered.
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end

        if (out_hs && s2_taken_q && (cnt_q != {TAKEN_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + TAKEN_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_flags_q   <= '0;
            s1_op_q      <= '0;
            s1_tag_q     <= '0;
            s2_vld_q     <= 1'b0;
            s2_taken_q   <= 1'b0;
            s2_illegal_q <= 1'b0;
            s2_flags_q   <= '0;
            s2_tag_q     <= '0;
            cnt_q        <= '0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_flags_q   <= s1_flags_d;
            s1_op_q      <= s1_op_d;
            s1_tag_q     <= s1_tag_d;
            s2_vld_q     <= s2_vld_d;
            s2_taken_q   <= s2_taken_d;
            s2_illegal_q <= s2_illegal_d;
            s2_flags_q   <= s2_flags_d;
            s2_tag_q     <= s2_tag_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = s2_vld_q;
    assign out_taken   = s2_taken_q;
    assign out_illegal = s2_illegal_q;
    assign out_flags   = s2_flags_q;
    assign out_tag     = s2_tag_q;
    assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: vector table, hand sequences, randomized model run.
module tb_branch_cond_unit;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [2:0]       in_op = '0;
    logic             in_signed = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_taken;
    logic             out_illegal;
    logic [2:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      taken_cnt;

    always #5 clk = ~clk;

    branch_cond_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
`ifdef BRANCH_SIGNED_EN
        .in_signed   (in_signed),
`endif
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_taken   (out_taken),
        .out_illegal (out_illegal),
        .out_flags   (out_flags),
        .out_tag     (out_tag),
        .taken_cnt   (taken_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic             taken;
        logic             illegal;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
    } res_t;

    // Reference: compare as integers, then apply the opcode's branch rule.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                   input logic sgn, input logic [TAG_W-1:0] tag);
        int   ia, ib;
        res_t r;
        ia = (sgn && a[7]) ? int'(a) - 256 : int'(a);
        ib = (sgn && b[7]) ? int'(b) - 256 : int'(b);
        r.flags   = {ia < ib, ia == ib, ia > ib};
        r.illegal = (op >= 3'd6);
        case (op)
            3'd0:    r.taken = (ia == ib);
            3'd1:    r.taken = (ia != ib);
            3'd2:    r.taken = (ia < ib);
            3'd3:    r.taken = (ia >= ib);
            3'd4:    r.taken = (ia > ib);
            3'd5:    r.taken = (ia <= ib);
            default: r.taken = 1'b0;
        endcase
        r.tag = tag;
        return r;
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       sgn;
        logic [3:0] tag;
        logic       exp_taken;
        logic       exp_illegal;
        logic [2:0] exp_flags;
    } vec_t;

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One isolated request with out_ready=1; checks latency and result fields.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        check($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = v.a; in_b = v.b; in_op = v.op; in_signed = v.sgn; in_tag = v.tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_lat_early", idx), out_valid, 0);
        @(negedge clk);
        check($sformatf("v%0d_valid", idx), out_valid, 1);
        check($sformatf("v%0d_taken", idx), out_taken, v.exp_taken);
        check($sformatf("v%0d_illegal", idx), out_illegal, v.exp_illegal);
        check($sformatf("v%0d_flags", idx), out_flags, v.exp_flags);
        check($sformatf("v%0d_tag", idx), out_tag, v.tag);
    endtask

    vec_t        vecs[$];
    res_t        exp_q[$];
    logic        got[$];
    logic [3:0]  got_tag[$];
    res_t        r;
    int          model_cnt;
    int          first_c, last_c;
    logic        accepted;
    logic        saw_valid;

    initial begin
        // a, b, op, signed, tag, taken, illegal, flags{lt,eq,gt}
        vecs.push_back('{8'h05, 8'h09, 3'd2, 1'b0, 4'h1, 1'b1, 1'b0, 3'b100});
        vecs.push_back('{8'h3C, 8'h3C, 3'd0, 1'b0, 4'h2, 1'b1, 1'b0, 3'b010});
        vecs.push_back('{8'h3C, 8'h3C, 3'd1, 1'b0, 4'h3, 1'b0, 1'b0, 3'b010});
        vecs.push_back('{8'hFF, 8'h01, 3'd4, 1'b0, 4'h4, 1'b1, 1'b0, 3'b001});
        vecs.push_back('{8'h00, 8'hFF, 3'd5, 1'b0, 4'h5, 1'b1, 1'b0, 3'b100});
        vecs.push_back('{8'h80, 8'h7F, 3'd3, 1'b0, 4'h6, 1'b1, 1'b0, 3'b001});
        vecs.push_back('{8'h10, 8'h20, 3'd7, 1'b0, 4'h7, 1'b0, 1'b1, 3'b100});
        vecs.push_back('{8'h20, 8'h10, 3'd6, 1'b0, 4'h8, 1'b0, 1'b1, 3'b001});
        vecs.push_back('{8'h7F, 8'h80, 3'd2, 1'b0, 4'h9, 1'b1, 1'b0, 3'b100});
        vecs.push_back('{8'hAA, 8'hAA, 3'd3, 1'b0, 4'hA, 1'b1, 1'b0, 3'b010});
`ifdef BRANCH_SIGNED_EN
        vecs.push_back('{8'hFF, 8'h01, 3'd4, 1'b1, 4'hB, 1'b0, 1'b0, 3'b100});
        vecs.push_back('{8'hFF, 8'h01, 3'd4, 1'b0, 4'hC, 1'b1, 1'b0, 3'b001});
        vecs.push_back('{8'h80, 8'h7F, 3'd2, 1'b1, 4'hD, 1'b1, 1'b0, 3'b100});
`endif

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_taken", out_taken, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_taken_cnt", taken_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back ops 0..5 on equal operands
        do_reset();
        got.delete(); first_c = -1; last_c = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c < 6) begin
                in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h3C; in_op = 3'(c); in_signed = 1'b0; in_tag = 4'(c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 6) check($sformatf("b2b_in_ready%0d", c), in_ready, 1);
            if (out_valid) begin
                got.push_back(out_taken);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        check("b2b_count", got.size(), 6);
        if (got.size() == 6)
            check("b2b_pattern", {got[0], got[1], got[2], got[3], got[4], got[5]}, 6'b100101);
        check("b2b_no_bubble", last_c - first_c, 5);
        check("b2b_taken_cnt", taken_cnt, 3);

        // Backpressure: three requests, out_ready low for 5 cycles
        do_reset();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02; in_op = 3'd2; in_tag = 4'h1;
        @(posedge clk); #1;
        in_tag = 4'h2;
        @(posedge clk); #1;
        in_tag = 4'h3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready%0d", c), in_ready, 0);
            check($sformatf("bp_out_valid%0d", c), out_valid, 1);
            check($sformatf("bp_out_hold%0d", c), {out_taken, out_flags, out_tag}, {1'b1, 3'b100, 4'h1});
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        #1 check("bp_in_ready_rise", in_ready, 1);
        got_tag.delete();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got_tag.push_back(out_tag);
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted) in_valid = 1'b0;
        end
        check("bp_result_count", got_tag.size(), 3);
        if (got_tag.size() == 3)
            check("bp_order", {got_tag[0], got_tag[1], got_tag[2]}, {4'h1, 4'h2, 4'h3});

        // Flush with both stages full
        do_reset();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'h05; in_b = 8'h05; in_op = 3'd0; in_tag = 4'h5;
        @(posedge clk); #1;
        in_tag = 4'h6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_pre_full", {out_valid, in_ready}, 2'b10);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_tag = 4'h7;
        #1 check("fl_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("fl_out_valid", out_valid, 0);
        saw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("fl_no_flushed_tag", saw_valid, 0);
        check("fl_taken_cnt", taken_cnt, 0);

        // Reset mid-stream (with flush also high)
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 8'h11; in_b = 8'h11; in_op = 3'd0; in_tag = 4'(c + 1);
        end
        @(negedge clk);
        check("mr_pre_cnt_nonzero", taken_cnt != 0, 1);
        check("mr_pre_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("mr_outputs", {out_valid, out_taken, out_illegal, out_flags, out_tag}, 0);
        check("mr_taken_cnt", taken_cnt, 0);
        check("mr_in_ready", in_ready, 1);

        // Randomized run against the reference model
        do_reset();
        exp_q.delete();
        model_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            in_a      = 8'($urandom);
            in_b      = (($urandom % 4) == 0) ? in_a : 8'($urandom);
            in_op     = 3'($urandom % 8);
`ifdef BRANCH_SIGNED_EN
            in_signed = 1'($urandom % 2);
`else
            in_signed = 1'b0;
`endif
            in_tag    = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 32) == 0;
            @(negedge clk);
            check("rnd_taken_cnt", taken_cnt, model_cnt);
            check("rnd_in_ready", in_ready, !flush && (exp_q.size() < 2 || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_out", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("rnd_result", {out_taken, out_illegal, out_flags, out_tag}, r);
                    if (r.taken && model_cnt < 65535) model_cnt++;
                end
            end
            if (flush) exp_q.delete();
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_op, in_signed, in_tag));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

        // Counter saturation
        do_reset();
        in_valid = 1'b1; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0; in_tag = 4'h0; out_ready = 1'b1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat_at_max", taken_cnt, 16'hFFFF);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sat_hold", taken_cnt, 16'hFFFF);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Pipelined, parametrised branch-condition resolver for the Mk1 datapath. It takes two operands, a branch opcode and a tag, and computes the less/equal/greater flags internally. It then returns a registered taken/not-taken decision through a valid/ready handshake. It sits between the register-read stage and the fetch/PC-update logic, and it supersedes the fixed 6-bit flag decoder.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥ 2.
- `TAG_W`, default 4: width of the opaque tag carried alongside each request.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: drops all in-flight requests.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `in_a` in `WIDTH`: operand A.
- `in_b` in `WIDTH`: operand B.
- `in_op` in 3: branch opcode.
- `in_signed` in 1: signed compare; present only with `BRANCH_SIGNED_EN`.
- `in_tag` in `TAG_W`: request tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_taken` out 1: branch taken.
- `out_illegal` out 1: opcode was 6 or 7.
- `out_flags` out 3: `{lt, eq, gt}` of A vs B.
- `out_tag` out `TAG_W`: tag of the result.
- `taken_cnt` out 16: count of taken results consumed.

## Operation
- Opcodes:
  - 0 BEQ: eq
  - 1 BNE: !eq
  - 2 BLT: lt
  - 3 BGE: !lt
  - 4 BGT: gt
  - 5 BLE: !gt
  - 6, 7: illegal. `out_taken` = 0, `out_illegal` = 1, `out_flags` still valid.
- Exactly one of lt/eq/gt is 1 for every result.
- Stage S1 registers the flags, op and tag on a handshake (`in_valid && in_ready`).
- Stage S2 registers taken, illegal, flags and tag.
- A stage loads when it is empty or when its contents advance in the same cycle. This gives full throughput of one result per cycle with no bubbles under continuous `out_ready`.
- `in_ready` = !`flush` && (!S1.valid || S1 advances). It is combinational from `out_ready` through the stage-occupancy chain.
- Backpressure: while `out_valid` && !`out_ready`, all S2 outputs are held stable, and S1 holds if full.
- `flush`: both stage valids clear at the edge. No request is accepted in a flush cycle. A result handshaken in the flush cycle (`out_valid && out_ready`) counts as delivered.
- `taken_cnt` increments on each `out_valid && out_ready && out_taken`. It saturates at 0xFFFF and clears only on `rst`.

## Timing
- Reset: S1/S2 valids = 0, `out_valid` = 0, `out_taken` = 0, `out_illegal` = 0, `out_flags` = 0, `out_tag` = 0, `taken_cnt` = 0. `in_ready` = 1 from the first cycle after reset deasserts.
- Latency: a request accepted at edge k produces `out_valid` = 1 after edge k+1, visible in cycle k+1 … k+2. That is two register stages: S1 at edge k, S2 at edge k+1.
- Reset mid-operation overrides `flush` and any handshake. All in-flight results are discarded and the counter clears.
- Simultaneous `flush` and `rst`: reset behaviour applies.
- Full pipeline with `out_ready` = 0: `in_ready` = 0 until `out_ready` rises. It then rises in the same cycle.

## Configuration
- `BRANCH_SIGNED_EN` defined: the `in_signed` port exists and is captured in S1. When 1, A and B compare as two's complement.
- `BRANCH_SIGNED_EN` undefined: no `in_signed` port; all compares are unsigned.

## Structure
- Package `branch_pkg`: opcode localparams (`OP_BEQ` … `OP_BLE`), flag bit indices (`FLAG_LT`, `FLAG_EQ`, `FLAG_GT`), `TAKEN_CNT_W` = 16.
- Sub-module `mag_compare`: combinational, with inputs A, B, signed and outputs lt/eq/gt. Instantiated once, feeding S1.
- Top holds the S1/S2 registers, the handshake logic, opcode decode and the counter.

## Test plan
- WIDTH=8; A=0x05, B=0x09, op=BLT, `out_ready`=1 → two cycles later `out_taken`=1, `out_flags`=100, tag echoed.
- Signed build: A=0xFF, B=0x01, op=BGT, signed=1 → taken=0, flags=100. Same operands with signed=0 → taken=1, flags=001.
- Six back-to-back requests, ops 0–5 with A=B=0x3C → taken pattern 1,0,0,1,0,1, with no bubbles and `taken_cnt`=3.
- `out_ready` held 0 for 5 cycles after 3 requests → `in_ready` falls once S1 and S2 are full, S2 outputs stay unchanged, and all 3 results emerge in order when `out_ready`=1.
- `flush` asserted with S1 and S2 full → `out_valid`=0 the next cycle, `in_ready`=0 during the flush cycle, and no flushed tag appears. op=7 → `out_illegal`=1, `taken`=0.
- Force 0xFFFF taken results (or preload via test hook) → `taken_cnt` saturates at 0xFFFF. `rst` mid-stream → all outputs return to their reset values on the next cycle.
